// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory with fixed access latency and valid/ready request/response.
// Optional DMEM_ALIGN_CHECK_EN flags misaligned addresses as errors.
module dmem_responder #(
    parameter int N       = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic         i_req_we,
    input  logic [N-1:0] i_req_addr,
    input  logic [N-1:0] i_req_wdata,
    output logic         o_resp_valid,
    input  logic         i_resp_ready,
    output logic [N-1:0] o_resp_rdata,
    output logic         o_resp_err
);
    localparam int AW = $clog2(DEPTH);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be within 1..15");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         r_state, w_next;
    logic [3:0]     r_cnt;
    logic           r_we;
    logic [N-1:0]   r_addr, r_wdata, r_rdata;
    logic           r_err;
    logic [N-1:0]   r_mem [DEPTH];
    logic           w_accept, w_commit, w_err;
    logic [AW-1:0]  w_idx;

    assign w_accept = (r_state == IDLE) && i_req_valid;
    assign w_commit = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_idx    = r_addr[AW+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
    assign w_err    = (|r_addr[N-1:AW+2]) || (|r_addr[1:0]);
`else
    logic w_unused;
    assign w_unused = ^r_addr[1:0];
    assign w_err    = |r_addr[N-1:AW+2];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_req_valid ? WAIT : IDLE;
            WAIT:    w_next = (r_cnt == 4'd0) ? RESP : WAIT;
            RESP:    w_next = i_resp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= 4'(LATENCY - 1);
                r_we    <= i_req_we;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_rdata <= (!w_err && !r_we) ? r_mem[w_idx] : '0;
                r_err   <= w_err;
            end
        end
    end

    // Storage has no reset so contents survive rst_n; writes only happen at commit.
    always_ff @(posedge clk) begin
        if (w_commit && r_we && !w_err) r_mem[w_idx] <= r_wdata;
    end

    assign o_req_ready  = (r_state == IDLE);
    assign o_resp_valid = (r_state == RESP);
    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against a cycle-count reference model.
module tb_dmem_responder;
    localparam int L = 2;
    localparam int D = 64;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        i_req_valid = 0, i_req_we = 0, i_resp_ready = 0;
    logic [31:0] i_req_addr = 0, i_req_wdata = 0;
    logic        o_req_ready, o_resp_valid, o_resp_err;
    logic [31:0] o_resp_rdata;

    int n_vec = 0, n_miss = 0;

    dmem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: a request accepted at cycle t commits at cycle t+L, then waits for a handshake.
    logic [31:0] m_mem [D];
    bit          m_known [D];
    bit          busy = 0, rsp = 0, e_known = 1, e_err = 0, p_we = 0;
    int          cyc = 0, t_acc = 0;
    logic [31:0] p_addr = 0, p_wdata = 0, e_rdata = 0;

    function automatic bit addr_err(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return (a[31:2] >= D) || (a[1:0] != 2'b00);
`else
        return a[31:2] >= D;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 0; rsp = 0; e_rdata = 0; e_err = 0; e_known = 1;
        end else begin
            cyc++;
            if (rsp) begin
                if (i_resp_ready) rsp = 0;
            end else if (busy) begin
                if (cyc == t_acc + L) begin
                    int idx;
                    idx = int'(p_addr[7:2]);
                    e_err = addr_err(p_addr);
                    if (!e_err && p_we) begin m_mem[idx] = p_wdata; m_known[idx] = 1; end
                    e_rdata = (!e_err && !p_we) ? m_mem[idx] : 32'h0;
                    e_known = e_err || p_we || m_known[idx];
                    busy = 0; rsp = 1;
                end
            end else if (i_req_valid) begin
                busy = 1; t_acc = cyc; p_we = i_req_we; p_addr = i_req_addr; p_wdata = i_req_wdata;
            end
        end
    end

    always @(negedge clk) begin
        check("req_ready", {31'b0, o_req_ready}, {31'b0, !busy && !rsp});
        check("resp_valid", {31'b0, o_resp_valid}, {31'b0, rsp});
        if (rsp) begin
            check("resp_err", {31'b0, o_resp_err}, {31'b0, e_err});
            if (e_known) check("resp_rdata", o_resp_rdata, e_rdata);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start(input bit we, input logic [31:0] a, input logic [31:0] d);
        bit acc = 0;
        i_req_we = we; i_req_addr = a; i_req_wdata = d; i_req_valid = 1;
        for (int i = 0; i < 50 && !acc; i++) begin acc = o_req_ready; tick(); end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        i_req_valid = 1'($urandom_range(0, 1));
        i_req_we = 1'($urandom_range(0, 1));
        i_req_addr = $urandom; i_req_wdata = $urandom;
    endtask

    task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] d, input int stall,
                       output logic [31:0] rd, output bit er, output int lat);
        start(we, a, d);
        lat = 0;
        while (!o_resp_valid && lat < 100) begin
            i_resp_ready = 1'($urandom_range(0, 1)); tick(); lat++;
        end
        if (!o_resp_valid) check("resp_timeout", 32'd0, 32'd1);
        rd = o_resp_rdata; er = o_resp_err;
        for (int s = 0; s < stall; s++) begin
            i_resp_ready = 0; i_req_valid = 1; tick();
            check("stall_rdata", o_resp_rdata, rd);
            check("stall_req_ready", {31'b0, o_req_ready}, 32'd0);
        end
        i_req_valid = 0; i_resp_ready = 1; tick();
        i_resp_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [31:0] rd;
        bit er;
        int lat;
        repeat (2) tick();
        check("rst_req_ready", {31'b0, o_req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, o_resp_valid}, 32'd0);
        check("rst_rdata", o_resp_rdata, 32'd0);
        check("rst_err", {31'b0, o_resp_err}, 32'd0);
        rst_n = 1;
        tick();

        txn(1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
        check("st_err", {31'b0, er}, 32'd0);
        check("st_rdata", rd, 32'd0);
        check("st_lat", lat, 32'd2);
        check("model_mem4", m_mem[4], 32'hDEADBEEF);
        txn(0, 32'h10, 32'h0, 0, rd, er, lat);
        check("ld_rdata", rd, 32'hDEADBEEF);
        check("ld_lat", lat, 32'd2);
        txn(1, 32'h14, 32'h1, 0, rd, er, lat);
        txn(0, 32'h10, 32'h0, 0, rd, er, lat);
        check("ld_after_14", rd, 32'hDEADBEEF);

        txn(1, 32'h0, 32'h0000A5A5, 0, rd, er, lat);
        txn(1, 32'h100, 32'hFFFFFFFF, 0, rd, er, lat);
        check("oor_st_err", {31'b0, er}, 32'd1);
        txn(0, 32'h0, 32'h0, 0, rd, er, lat);
        check("ld0_unchanged", rd, 32'h0000A5A5);
        txn(0, 32'h100, 32'h0, 0, rd, er, lat);
        check("oor_ld_err", {31'b0, er}, 32'd1);
        check("oor_ld_rdata", rd, 32'd0);

        txn(0, 32'h14, 32'h0, 5, rd, er, lat);
        check("bp_rdata", rd, 32'h1);
        check("bp_ready_after", {31'b0, o_req_ready}, 32'd1);
        txn(0, 32'h10, 32'h0, 0, rd, er, lat);
        check("bp_next_lat", lat, 32'd2);

        txn(1, 32'h20, 32'h00000055, 0, rd, er, lat);
        start(1, 32'h20, 32'h12345678);
        i_req_valid = 0; i_resp_ready = 0;
        rst_n = 0; #1;
        check("rstw_resp_valid", {31'b0, o_resp_valid}, 32'd0);
        check("rstw_req_ready", {31'b0, o_req_ready}, 32'd1);
        tick(); tick(); rst_n = 1; tick();
        txn(0, 32'h20, 32'h0, 0, rd, er, lat);
        check("rstw_ld20", rd, 32'h00000055);

        start(1, 32'h24, 32'h00000077);
        i_req_valid = 0; i_resp_ready = 0;
        for (int i = 0; i < 20 && !o_resp_valid; i++) tick();
        rst_n = 0; #1;
        check("rstr_resp_valid", {31'b0, o_resp_valid}, 32'd0);
        tick(); rst_n = 1; tick();
        txn(0, 32'h24, 32'h0, 0, rd, er, lat);
        check("rstr_ld24", rd, 32'h00000077);

        txn(1, 32'h22, 32'h0000CAFE, 0, rd, er, lat);
        txn(0, 32'h20, 32'h0, 0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
        check("align_ld20", rd, 32'h00000055);
`else
        check("align_ld20", rd, 32'h0000CAFE);
`endif

        for (int t = 0; t < 200; t++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? $urandom
                : {22'b0, 8'($urandom_range(0, 79)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'b00;
            i_req_valid = 0;
            repeat ($urandom_range(0, 2)) tick();
            txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), rd, er, lat);
        end

        i_req_valid = 0;
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
